// File: rtl/vip_cheshire_uart_pkg.sv
// Shared types and constants for the Cheshire VIP UART receiver.
package vip_cheshire_uart_pkg;

   localparam int unsigned MinDiv   = 4;
   localparam int unsigned DataBits = 8;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StBreak
   } uart_rx_state_e;

   typedef struct packed {
      logic                frame_err;
      logic [DataBits-1:0] data;
   } uart_rx_entry_t;

endpackage

// File: rtl/vip_cheshire_uart_rx_fifo.sv
// Small synchronous-reset FIFO; head entry is read straight from the storage flops.
module vip_cheshire_uart_rx_fifo #(
   parameter int unsigned Depth   = 4,
   parameter type         entry_t = logic [8:0]
) (
   input  logic   clk_i,
   input  logic   rst_ni,
   input  logic   push_i,
   input  entry_t entry_i,
   output logic   full_o,
   input  logic   pop_i,
   output logic   valid_o,
   output entry_t entry_o
);

   localparam int unsigned PtrW = $clog2(Depth);

   logic [PtrW:0] r_wr_ptr;
   logic [PtrW:0] r_rd_ptr;
   entry_t        r_mem [Depth];

   logic w_full;
   logic w_empty;
   logic w_do_pop;
   logic w_do_push;

   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_full    = (r_wr_ptr[PtrW] != r_rd_ptr[PtrW]) &&
                      (r_wr_ptr[PtrW-1:0] == r_rd_ptr[PtrW-1:0]);
   assign w_do_pop  = pop_i && !w_empty;
   // A pop in the same cycle frees the slot the push lands in.
   assign w_do_push = push_i && (!w_full || w_do_pop);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int i = 0; i < int'(Depth); i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr[PtrW-1:0]] <= entry_i;
            r_wr_ptr                  <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   assign full_o  = w_full;
   assign valid_o = !w_empty;
   assign entry_o = r_mem[r_rd_ptr[PtrW-1:0]];

endmodule

// File: rtl/vip_cheshire_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, output FIFO with
// valid/ready handshake and per-byte framing-error flag.
module vip_cheshire_uart_rx
   import vip_cheshire_uart_pkg::*;
#(
   parameter int unsigned DivWidth  = 16,
   parameter int unsigned FifoDepth = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                en_i,
   input  logic [DivWidth-1:0] div_i,
   input  logic                rx_i,
   output logic [7:0]          data_o,
   output logic                frame_err_o,
   output logic                valid_o,
   input  logic                ready_i,
   output logic                overflow_o,
   output logic                busy_o
);

   localparam int unsigned IdxW = $clog2(DataBits);

   logic                r_rx_meta, r_rx_s, r_rx_p;
   uart_rx_state_e      r_state, w_state_d;
   logic [DivWidth-1:0] r_cnt, w_cnt_d;
   logic [DivWidth-1:0] r_div_l, w_div_l_d;
   logic [IdxW-1:0]     r_idx, w_idx_d;
   logic [7:0]          r_shift, w_shift_d;
   logic                r_overflow;

   logic                w_tick;
   logic                w_push;
   logic                w_pop;
   logic                w_full;
   logic                w_valid;
   logic [DivWidth-1:0] w_div_clamp;
   uart_rx_entry_t      w_entry;
   uart_rx_entry_t      w_head;

   assign w_div_clamp = (div_i < DivWidth'(MinDiv)) ? DivWidth'(MinDiv) : div_i;
   assign w_tick      = (r_cnt == '0);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_rx_meta  <= 1'b1;
         r_rx_s     <= 1'b1;
         r_rx_p     <= 1'b1;
         r_state    <= StIdle;
         r_cnt      <= '0;
         r_div_l    <= '0;
         r_idx      <= '0;
         r_shift    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_rx_meta  <= rx_i;
         r_rx_s     <= r_rx_meta;
         r_rx_p     <= r_rx_s;
         r_state    <= w_state_d;
         r_cnt      <= w_cnt_d;
         r_div_l    <= w_div_l_d;
         r_idx      <= w_idx_d;
         r_shift    <= w_shift_d;
         r_overflow <= w_push && w_full && !w_pop;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_div_l_d = r_div_l;
      w_idx_d   = r_idx;
      w_shift_d = r_shift;
      w_push    = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (en_i && r_rx_p && !r_rx_s) begin
               w_state_d = StStart;
               w_div_l_d = w_div_clamp;
               w_cnt_d   = (w_div_clamp >> 1) - DivWidth'(1);
            end
         end
         StStart: begin
            if (!w_tick) begin
               w_cnt_d = r_cnt - DivWidth'(1);
            end else if (!r_rx_s) begin
               w_state_d = StData;
               w_cnt_d   = r_div_l - DivWidth'(1);
               w_idx_d   = '0;
            end else begin
               w_state_d = StIdle;
            end
         end
         StData: begin
            if (!w_tick) begin
               w_cnt_d = r_cnt - DivWidth'(1);
            end else begin
               w_shift_d[r_idx] = r_rx_s;
               w_cnt_d          = r_div_l - DivWidth'(1);
               if (r_idx == IdxW'(DataBits - 1)) begin
                  w_state_d = StStop;
               end else begin
                  w_idx_d = r_idx + IdxW'(1);
               end
            end
         end
         StStop: begin
            if (!w_tick) begin
               w_cnt_d = r_cnt - DivWidth'(1);
            end else begin
               w_push    = 1'b1;
               w_state_d = r_rx_s ? StIdle : StBreak;
            end
         end
         StBreak: begin
            // Held-low line: wait for release so it yields only one errored byte.
            if (r_rx_s) begin
               w_state_d = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
      if (!en_i) begin
         w_state_d = StIdle;
         w_push    = 1'b0;
      end
   end

   assign w_entry.frame_err = ~r_rx_s;
   assign w_entry.data      = r_shift;
   assign w_pop             = w_valid && ready_i;

   vip_cheshire_uart_rx_fifo #(
      .Depth   (FifoDepth),
      .entry_t (uart_rx_entry_t)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (w_push),
      .entry_i (w_entry),
      .full_o  (w_full),
      .pop_i   (w_pop),
      .valid_o (w_valid),
      .entry_o (w_head)
   );

   assign data_o      = w_head.data;
   assign frame_err_o = w_head.frame_err;
   assign valid_o     = w_valid;
   assign overflow_o  = r_overflow;
   assign busy_o      = (r_state != StIdle);

endmodule

// File: tb/tb_vip_cheshire_uart_rx.sv
// Self-checking bench for vip_cheshire_uart_rx: table vectors, directed corner cases
// and randomized frames scored against a queue-based reference.
module tb_vip_cheshire_uart_rx;

   localparam int unsigned DivWidth = 16;

   logic                clk = 1'b0;
   logic                rst_ni;
   logic                en_i;
   logic [DivWidth-1:0] div_i;
   logic                rx_i;
   logic [7:0]          data_o;
   logic                frame_err_o;
   logic                valid_o;
   logic                ready_i;
   logic                overflow_o;
   logic                busy_o;

   always #5 clk = ~clk;

   vip_cheshire_uart_rx #(
      .DivWidth  (DivWidth),
      .FifoDepth (4)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .en_i        (en_i),
      .div_i       (div_i),
      .rx_i        (rx_i),
      .data_o      (data_o),
      .frame_err_o (frame_err_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .overflow_o  (overflow_o),
      .busy_o      (busy_o)
   );

   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          n_ovf = 0;
   int          rise_cyc = -1;
   int          t0 = 0;
   logic        prev_valid = 1'b0;
   logic [8:0]  rx_q[$];
   logic [8:0]  exp_q[$];
   bit          rand_run = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Observe handshakes and pulses away from the active edge.
   always @(negedge clk) begin
      if (valid_o && ready_i) rx_q.push_back({frame_err_o, data_o});
      if (overflow_o) n_ovf++;
      if (valid_o && !prev_valid) rise_cyc = cyc;
      prev_valid = valid_o;
   end

   typedef struct {
      logic [7:0]  data;
      logic        stop;
      int unsigned div;
      logic [7:0]  exp_data;
      logic        exp_err;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int unsigned eff_div(input int unsigned d);
      return (d < 4) ? 4 : d;
   endfunction

   // Line level during bit slot i of an 8N1 frame; slots past the stop bit keep its level.
   function automatic logic line_bit(input logic [7:0] d, input logic stop, input int unsigned i);
      if (i == 0) return 1'b0;
      else if (i <= 8) return d[i-1];
      else return stop;
   endfunction

   task automatic idle(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_line(input logic [7:0] d, input logic stop, input int unsigned div,
                             input int unsigned ncyc, input bit scramble);
      for (int unsigned c = 0; c < ncyc; c++) begin
         @(posedge clk);
         #1;
         if (c == 0) t0 = cyc;
         rx_i = line_bit(d, stop, c / div);
         if (scramble && c == 6) div_i = DivWidth'($urandom);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input int unsigned div,
                             input int unsigned gap, input int unsigned hold, input bit scramble);
      div_i = DivWidth'(div);
      repeat (gap) begin
         @(posedge clk);
         #1;
         rx_i = 1'b1;
      end
      drive_line(d, stop, eff_div(div), 10 * eff_div(div) + hold, scramble);
      @(posedge clk);
      #1;
      rx_i = 1'b1;
   endtask

   initial begin
      int ovf0;
      int unsigned k;
      logic [7:0] d;
      logic st;
      int unsigned dv;

      vecs[0] = '{8'h00, 1'b1, 4,  8'h00, 1'b0};
      vecs[1] = '{8'hFF, 1'b1, 3,  8'hFF, 1'b0};
      vecs[2] = '{8'h5A, 1'b1, 5,  8'h5A, 1'b0};
      vecs[3] = '{8'h81, 1'b0, 7,  8'h81, 1'b1};
      vecs[4] = '{8'hC3, 1'b1, 33, 8'hC3, 1'b0};
      vecs[5] = '{8'h7E, 1'b0, 4,  8'h7E, 1'b1};

      rst_ni  = 1'b0;
      en_i    = 1'b1;
      div_i   = 16;
      rx_i    = 1'b1;
      ready_i = 1'b0;
      idle(3);
      rst_ni = 1'b1;
      check("reset data_o", data_o, 0);
      check("reset frame_err_o", frame_err_o, 0);
      check("reset valid_o", valid_o, 0);
      check("reset overflow_o", overflow_o, 0);
      check("reset busy_o", busy_o, 0);
      idle(4);

      // Single byte, valid latency after the stop-bit sample.
      rx_q.delete();
      ready_i  = 1'b1;
      rise_cyc = -1;
      send_frame(8'hA5, 1'b1, 16, 4, 0, 1'b0);
      idle(40);
      check("a5 count", rx_q.size(), 1);
      if (rx_q.size() >= 1) check("a5 entry", rx_q[0], {1'b0, 8'hA5});
      check("a5 valid latency", rise_cyc - t0, 3 + 16 / 2 + 9 * 16);

      // Table vectors, including clamped divisor and framing errors.
      for (int i = 0; i < 6; i++) begin
         rx_q.delete();
         send_frame(vecs[i].data, vecs[i].stop, vecs[i].div, 5, 0, 1'b1);
         idle(2 * eff_div(vecs[i].div) + 10);
         check($sformatf("vec%0d count", i), rx_q.size(), 1);
         if (rx_q.size() >= 1)
            check($sformatf("vec%0d entry", i), rx_q[0], {vecs[i].exp_err, vecs[i].exp_data});
      end

      // Start-bit glitch.
      rx_q.delete();
      ovf0  = n_ovf;
      div_i = 16;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         rx_i = 1'b0;
      end
      check("glitch busy during", busy_o, 1);
      rx_i = 1'b1;
      idle(40);
      check("glitch count", rx_q.size(), 0);
      check("glitch busy after", busy_o, 0);
      check("glitch overflow", n_ovf - ovf0, 0);

      // Framing error followed by a long break, then a good byte.
      rx_q.delete();
      send_frame(8'h3C, 1'b0, 16, 5, 100, 1'b0);
      send_frame(8'h11, 1'b1, 16, 5, 0, 1'b0);
      idle(40);
      check("break count", rx_q.size(), 2);
      if (rx_q.size() >= 2) begin
         check("break entry0", rx_q[0], {1'b1, 8'h3C});
         check("break entry1", rx_q[1], {1'b0, 8'h11});
      end

      // FIFO full: fifth byte dropped.
      rx_q.delete();
      ready_i = 1'b0;
      ovf0    = n_ovf;
      for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 8, 4, 0, 1'b0);
      idle(20);
      check("full no overflow yet", n_ovf - ovf0, 0);
      send_frame(8'h05, 1'b1, 8, 4, 0, 1'b0);
      idle(20);
      check("full overflow pulses", n_ovf - ovf0, 1);
      ready_i = 1'b1;
      idle(20);
      check("full drain count", rx_q.size(), 4);
      for (int i = 0; i < 4 && i < rx_q.size(); i++)
         check($sformatf("full drain %0d", i), rx_q[i], {1'b0, 8'(i + 1)});

      // Full FIFO with a pop in the push cycle.
      rx_q.delete();
      ready_i = 1'b0;
      ovf0    = n_ovf;
      for (int i = 0; i < 4; i++) send_frame(8'h21 + 8'(i), 1'b1, 8, 4, 0, 1'b0);
      idle(10);
      t0 = -100000;
      fork
         send_frame(8'h25, 1'b1, 8, 4, 0, 1'b0);
         begin
            k = 0;
            while (k < 400 && cyc != t0 + 2 + 8 / 2 + 9 * 8) begin
               @(posedge clk);
               #1;
               k++;
            end
            ready_i = 1'b1;
            @(posedge clk);
            #1;
            ready_i = 1'b0;
         end
      join
      idle(20);
      check("simul overflow", n_ovf - ovf0, 0);
      check("simul popped", rx_q.size(), 1);
      check("simul still valid", valid_o, 1);
      ready_i = 1'b1;
      idle(20);
      check("simul total", rx_q.size(), 5);
      if (rx_q.size() == 5) check("simul last", rx_q[4], {1'b0, 8'h25});

      // Reset during data bit 3 with a stored entry.
      rx_q.delete();
      ready_i = 1'b0;
      send_frame(8'h96, 1'b0, 8, 5, 0, 1'b0);
      idle(30);
      check("pre-reset valid", valid_o, 1);
      div_i = 16;
      drive_line(8'hC3, 1'b1, 16, 4 * 16 + 8, 1'b0);
      rst_ni = 1'b0;
      rx_i   = 1'b1;
      @(posedge clk);
      #1;
      check("midrst data_o", data_o, 0);
      check("midrst frame_err_o", frame_err_o, 0);
      check("midrst valid_o", valid_o, 0);
      check("midrst busy_o", busy_o, 0);
      check("midrst overflow_o", overflow_o, 0);
      rst_ni = 1'b1;
      idle(10);
      rx_q.delete();
      ready_i = 1'b1;
      send_frame(8'h5A, 1'b1, 16, 5, 0, 1'b0);
      idle(40);
      check("post-reset count", rx_q.size(), 1);
      if (rx_q.size() >= 1) check("post-reset entry", rx_q[0], {1'b0, 8'h5A});

      // Enable dropped for one cycle mid-frame.
      rx_q.delete();
      drive_line(8'hC3, 1'b1, 16, 4 * 16 + 8, 1'b0);
      en_i = 1'b0;
      rx_i = 1'b1;
      @(posedge clk);
      #1;
      en_i = 1'b1;
      check("en abort busy", busy_o, 0);
      idle(200);
      check("en abort count", rx_q.size(), 0);
      send_frame(8'h5A, 1'b1, 16, 5, 0, 1'b0);
      idle(40);
      check("post-en count", rx_q.size(), 1);
      if (rx_q.size() >= 1) check("post-en entry", rx_q[0], {1'b0, 8'h5A});

      // Randomized frames with a random consumer.
      rx_q.delete();
      exp_q.delete();
      ovf0     = n_ovf;
      rand_run = 1'b1;
      fork
         while (rand_run) begin
            @(posedge clk);
            #1;
            ready_i = 1'($urandom_range(0, 1));
         end
      join_none
      for (int i = 0; i < 25; i++) begin
         d  = 8'($urandom);
         dv = $urandom_range(2, 20);
         st = ($urandom_range(0, 9) != 0);
         exp_q.push_back({~st, d});
         send_frame(d, st, dv, $urandom_range(4, 12), 0, 1'b1);
      end
      idle(40);
      rand_run = 1'b0;
      idle(3);
      ready_i = 1'b1;
      idle(20);
      check("rand count", rx_q.size(), exp_q.size());
      check("rand overflow", n_ovf - ovf0, 0);
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
         check($sformatf("rand entry %0d", i), rx_q[i], exp_q[i]);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
